pipelined_memory: RTL and testbench
===================================

Name: pipelined_memory

Overview:
- Parametrised successor to the single-cycle data memory.
- Word-organised synchronous RAM with a valid/ready request interface, configurable read latency and in-order responses.
- Self-clears to zero after reset and flags misaligned or out-of-range accesses.
- Sits between the datapath memory stage (or a future load/store unit) and on-chip storage.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of 8
ADDR_W, 16, byte address width
DEPTH, 1024, number of words; power of two
READ_LAT, 2, cycles from request accept to response; must be 1..4
ADDR_SHIFT, 1, log2(DATA_W/8); byte address to word index shift

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
resp_valid  out  1  response present (single-cycle pulse per request)
resp_rdata  out  DATA_W  read data; 0 for writes and errors
resp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset state (reset high at an edge):
  - state <= INIT, init index <= 0, response pipeline flushed.
  - req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0.
- INIT state:
  - Writes 0 to word[init index] each cycle, then increments the index.
  - After the write to index DEPTH-1 the next state is RUN, so INIT lasts exactly DEPTH cycles.
  - req_ready = 0 throughout INIT.
- RUN state:
  - req_ready = 1 always; responses have no backpressure.
  - A request is accepted on an edge where req_valid && req_ready.
- Word index: req_addr >> ADDR_SHIFT.
- Error conditions:
  - Misaligned: req_addr[ADDR_SHIFT-1:0] != 0.
  - Out of range: word index >= DEPTH.
  - Either condition sets err. An errored request performs no array access.
- Accepted write, no error: the array is updated at the accept edge.
- Accepted read, no error: the array is sampled at the accept edge, so a read accepted in the cycle after a write to the same word returns the new data.
- Responses:
  - Every accepted request yields exactly one response.
  - A request accepted at edge N has resp_valid high during the cycle after edge N+READ_LAT-1, i.e. READ_LAT cycles later.
  - Responses are strictly in order, one request per cycle max, full throughput.
  - Response fields: resp_err = err; resp_rdata = read data for a good read, else 0.
- Reset mid-operation:
  - In-flight responses are dropped and never emitted.
  - INIT restarts at index 0, so all contents are cleared.
- Requests while req_ready = 0 are ignored (no response, no side effect).
- Width rules: the index is truncated to clog2(DEPTH) bits only after the range check on the full shifted address.

Optional Feature:
- Macro MEM_BYTE_EN_EN.
- Defined:
  - Adds port req_be, in, DATA_W/8 bits.
  - On a write, only bytes with req_be[k]=1 are updated.
  - A write with req_be = 0 is legal: response is produced, no data change.
  - Reads and INIT ignore req_be.
- Undefined:
  - No req_be port; writes update the full word.

Decomposition:
- Shared package mem_pkg:
  - State enum {INIT, RUN}.
  - Response stage struct {valid, err, rdata}.
  - Constant for maximum READ_LAT (4).
  - Function computing the index width from DEPTH.
- Sub-module mem_resp_pipe:
  - READ_LAT-1 stage shift register of the response struct, with synchronous flush on reset.
  - Stage 0 is the registered array output plus the valid/err flags.

Test Plan:
- Init timing: deassert reset, hold req_valid=1 -> req_ready low for exactly 1024 cycles, then high; reads of 0x0000 and 0x07FE return 0 with resp_err=0.
- Sweep: write addr i*2, data i for i=0..63 back-to-back, then read the same addresses -> each resp_valid 2 cycles after accept with resp_rdata=i; 64 consecutive responses in order.
- Write-then-read: write 0x1234 to 0x0010 at cycle N, read 0x0010 at N+1 -> response at N+3 with rdata 0x1234, err 0.
- Errors:
  - Read 0x0003 -> err=1, rdata=0.
  - Write 0xBEEF to 0x0003 -> err=1, word 0x0002 unchanged.
  - Read 0x0800 (index 1024) -> err=1.
- Reset mid-flight: issue reads at N and N+1, assert reset at N+1 -> no resp_valid afterwards; after re-INIT, previously written words read 0.
- With MEM_BYTE_EN_EN: write 0xFFFF to 0x0020, then write 0x1200 with req_be=2'b10 -> read returns 0x12FF.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types, limits and helpers for pipelined_memory.
package mem_pkg;
  typedef enum logic {INIT, RUN} state_e;
  localparam int MAX_READ_LAT = 4;
  localparam int MAX_DATA_W = 64;
  typedef struct packed {
    logic valid;
    logic err;
    logic [MAX_DATA_W-1:0] rdata;
  } resp_stage_t;
  function automatic int idx_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/pipelined_memory_if.sv
// pipelined_memory_if: request/response bus of pipelined_memory; req_be exists only with MEM_BYTE_EN_EN.
interface pipelined_memory_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
`ifdef MEM_BYTE_EN_EN
  logic [DATA_W/8-1:0] req_be;
`endif
  logic resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic resp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
`ifdef MEM_BYTE_EN_EN
    output req_be,
`endif
    input req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wdata,
`ifdef MEM_BYTE_EN_EN
    input req_be,
`endif
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe: LAT-deep response shift register; stage 0 captures the array output and flags.
module mem_resp_pipe
  import mem_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  resp_stage_t stage_i,
  output resp_stage_t stage_o
);
  resp_stage_t s_q [LAT];
  always_ff @(posedge clock)
    if (reset) s_q <= '{default: '0};
    else begin
      s_q[0] <= stage_i;
      for (int i = 1; i < LAT; i++) s_q[i] <= s_q[i-1];
    end
  assign stage_o = s_q[LAT-1];
endmodule

// File: rtl/pipelined_memory.sv
// pipelined_memory: self-clearing word RAM with valid/ready requests and fixed-latency in-order responses.
// Define MEM_BYTE_EN_EN to add per-byte write enables (req_be).
module pipelined_memory
  import mem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 1024,
  parameter int READ_LAT   = 2,
  parameter int ADDR_SHIFT = 1
) (
  input logic clock,
  input logic reset,
  pipelined_memory_if.slave bus
);
  localparam int IDX_W = idx_w(DEPTH);
  localparam int LAT = READ_LAT < 1 ? 1 : (READ_LAT > MAX_READ_LAT ? MAX_READ_LAT : READ_LAT);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << ADDR_SHIFT) - 1);
  state_e state_q, state_d;
  logic [IDX_W-1:0] init_q, init_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] word;
  logic [IDX_W-1:0] idx;
  logic err, accept, unused_rdata;
  resp_stage_t stage_in, stage_out;
  // range check uses the full shifted address; truncation to the index comes after
  assign word = bus.req_addr >> ADDR_SHIFT;
  assign idx = word[IDX_W-1:0];
  assign err = ((bus.req_addr & ALIGN_MASK) != '0) || ({1'b0, word} >= DEPTH_L);
  assign bus.req_ready = state_q == RUN;
  assign accept = bus.req_valid && bus.req_ready;
  always_comb begin
    init_d = state_q == INIT ? init_q + 1'b1 : init_q;
    state_d = (state_q == INIT && init_q == IDX_W'(DEPTH - 1)) ? RUN : state_q;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= INIT;
      init_q <= '0;
    end else begin
      state_q <= state_d;
      init_q <= init_d;
    end
  always_ff @(posedge clock)
    if (!reset) begin
      if (state_q == INIT) mem[init_q] <= '0;
      else if (accept && bus.req_write && !err) begin
`ifdef MEM_BYTE_EN_EN
        for (int k = 0; k < DATA_W/8; k++)
          if (bus.req_be[k]) mem[idx][8*k +: 8] <= bus.req_wdata[8*k +: 8];
`else
        mem[idx] <= bus.req_wdata;
`endif
      end
    end
  always_comb begin
    stage_in.valid = accept;
    stage_in.err = accept && err;
    stage_in.rdata = (accept && !bus.req_write && !err) ? MAX_DATA_W'(mem[idx]) : '0;
  end
  mem_resp_pipe #(.LAT(LAT)) u_pipe (
    .clock   (clock),
    .reset   (reset),
    .stage_i (stage_in),
    .stage_o (stage_out)
  );
  assign bus.resp_valid = stage_out.valid;
  assign bus.resp_err = stage_out.err;
  assign bus.resp_rdata = stage_out.rdata[DATA_W-1:0];
  assign unused_rdata = |(stage_out.rdata >> DATA_W);
endmodule

// File: tb/tb_pipelined_memory.sv
// tb_pipelined_memory: directed table-driven bench for pipelined_memory with default parameters.
module tb_pipelined_memory;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pipelined_memory_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  pipelined_memory dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        err;
    logic [15:0] rdata;
  } vec_t;

  vec_t v[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic wr, logic [15:0] addr, logic [15:0] wdata,
                              logic [1:0] be, logic err, logic [15:0] rdata);
    vec_t x;
    x.wr = wr; x.addr = addr; x.wdata = wdata; x.be = be; x.err = err; x.rdata = rdata;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(vec_t x, logic valid);
    bus.req_valid = valid;
    bus.req_write = x.wr;
    bus.req_addr = x.addr;
    bus.req_wdata = x.wdata;
`ifdef MEM_BYTE_EN_EN
    bus.req_be = x.be;
`endif
  endtask

  // back-to-back issue; with READ_LAT=2 the response to v[i-1] is visible right after the edge accepting v[i]
  task automatic run_table;
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= v.size(); i++) begin
      if (i < v.size()) drive(v[i], 1'b1);
      else drive(idle, 1'b0);
      step;
      if (i > 0) begin
        check($sformatf("v%0d@%0h valid", i-1, v[i-1].addr), bus.resp_valid, 1);
        check($sformatf("v%0d@%0h err", i-1, v[i-1].addr), bus.resp_err, v[i-1].err);
        check($sformatf("v%0d@%0h rdata", i-1, v[i-1].addr), bus.resp_rdata, v[i-1].rdata);
      end
    end
    step;
    check("table tail valid", bus.resp_valid, 0);
  endtask

  task automatic wait_init(string tag);
    int low = 0;
    int seen = 0;
    while (!bus.req_ready && low < 2000) begin
      low++;
      if (bus.resp_valid) seen++;
      step;
    end
    check({tag, " ready-low cycles"}, low, 1024);
    check({tag, " resp during init"}, seen, 0);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 2'b11, 0, 0);
    drive(idle, 1'b1);
    reset = 1'b1;
    step;
    step;
    check("reset ready", bus.req_ready, 0);
    check("reset resp_valid", bus.resp_valid, 0);
    check("reset rdata", bus.resp_rdata, 0);
    check("reset err", bus.resp_err, 0);
    reset = 1'b0;
    wait_init("init");
    drive(idle, 1'b0);
    check("run ready", bus.req_ready, 1);

    drive(mk(0, 16'h0000, 0, 2'b11, 0, 0), 1'b1);
    step;
    drive(idle, 1'b0);
    check("lat cycle1 valid", bus.resp_valid, 0);
    step;
    check("lat cycle2 valid", bus.resp_valid, 1);
    check("lat cycle2 rdata", bus.resp_rdata, 0);
    step;
    check("lat pulse end", bus.resp_valid, 0);

    v.push_back(mk(0, 16'h0000, 0, 2'b11, 0, 16'h0000));
    v.push_back(mk(0, 16'h07FE, 0, 2'b11, 0, 16'h0000));
    for (int i = 0; i < 64; i++) v.push_back(mk(1, 16'(i*2), 16'(i), 2'b11, 0, 0));
    for (int i = 0; i < 64; i++) v.push_back(mk(0, 16'(i*2), 0, 2'b11, 0, 16'(i)));
    v.push_back(mk(1, 16'h0010, 16'h1234, 2'b11, 0, 0));
    v.push_back(mk(0, 16'h0010, 0, 2'b11, 0, 16'h1234));
    v.push_back(mk(0, 16'h0003, 0, 2'b11, 1, 0));
    v.push_back(mk(1, 16'h0003, 16'hBEEF, 2'b11, 1, 0));
    v.push_back(mk(0, 16'h0002, 0, 2'b11, 0, 16'h0001));
    v.push_back(mk(0, 16'h0800, 0, 2'b11, 1, 0));
    v.push_back(mk(1, 16'h0800, 16'h5555, 2'b11, 1, 0));
    v.push_back(mk(0, 16'hFFFE, 0, 2'b11, 1, 0));
    v.push_back(mk(0, 16'h0000, 0, 2'b11, 0, 16'h0000));
`ifdef MEM_BYTE_EN_EN
    v.push_back(mk(1, 16'h0020, 16'hFFFF, 2'b11, 0, 0));
    v.push_back(mk(1, 16'h0020, 16'h1200, 2'b10, 0, 0));
    v.push_back(mk(0, 16'h0020, 0, 2'b00, 0, 16'h12FF));
    v.push_back(mk(1, 16'h0020, 16'hAAAA, 2'b00, 0, 0));
    v.push_back(mk(0, 16'h0020, 0, 2'b11, 0, 16'h12FF));
`endif
    run_table;

    drive(mk(0, 16'h0010, 0, 2'b11, 0, 0), 1'b1);
    step;
    drive(mk(0, 16'h0002, 0, 2'b11, 0, 0), 1'b1);
    reset = 1'b1;
    step;
    reset = 1'b0;
    drive(idle, 1'b0);
    check("midflight reset resp_valid", bus.resp_valid, 0);
    wait_init("reinit");

    v.delete();
    v.push_back(mk(0, 16'h0010, 0, 2'b11, 0, 16'h0000));
    v.push_back(mk(0, 16'h0002, 0, 2'b11, 0, 16'h0000));
    v.push_back(mk(0, 16'h007E, 0, 2'b11, 0, 16'h0000));
    run_table;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
